// File: rtl/psum_accumulator_pkg.sv
// psum_accumulator_pkg: shared state encoding and default widths for the sum/accumulate stages
package psum_accumulator_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam int DEF_IN_W      = 3;
    localparam int DEF_ACC_W     = 12;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_MAX_BEATS = 255;

endpackage

// File: rtl/psum_accumulator_sat_add.sv
// sat_add: zero-extend b, add to a, clamp to 2**A_W-1 (sat flags the clamp)
//   a   in  A_W  running value
//   b   in  B_W  addend (B_W <= A_W)
//   sum out A_W  clamped result
//   sat out 1    result was clamped
module sat_add #(
    parameter int A_W = 12,
    parameter int B_W = 3
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [A_W-1:0] sum,
    output logic           sat
);

    logic [A_W:0] raw;

    always_comb begin
        raw = {1'b0, a} + (A_W+1)'(b);
        sat = raw[A_W];
        sum = sat ? '1 : raw[A_W-1:0];
    end

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates partial-sum beats into frame totals behind a valid/ready output
//   clk, rst                async active-high reset
//   clr                     drop partial frame (pending result kept)
//   in_data/in_valid/in_last/in_ready   beat input
//   out_data/out_beats/out_ovf/out_err/out_valid/out_ready   frame result output
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_ovf,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_sum;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             ovf, sat, beat, xfer, close;

    sat_add #(.A_W(ACC_W), .B_W(IN_W)) u_add (
        .a   (acc),
        .b   (in_data),
        .sum (acc_sum),
        .sat (sat)
    );

    assign out_valid = (state == ST_HOLD);

    // In HOLD a beat is only taken when the pending result leaves in the same
    // cycle, so the new frame starts without a bubble and nothing is lost.
    always_comb begin
        in_ready  = ~rst & ~clr & ((state == ST_ACCUM) | out_ready);
        beat      = in_valid & in_ready;
        xfer      = out_valid & out_ready;
        cnt_inc   = cnt + 1'b1;
        close     = beat & (in_last | (cnt_inc == MAX_CNT));
        state_nxt = close ? ST_HOLD : xfer ? ST_ACCUM : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_ACCUM;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            if (clr | close) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (beat) begin
                acc <= acc_sum;
                cnt <= cnt_inc;
                ovf <= ovf | sat;
            end
            if (close) begin
                out_data  <= acc_sum;
                out_beats <= cnt_inc;
                out_ovf   <= ovf | sat;
                out_err   <= ~in_last;
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed + randomized check of psum_accumulator against a frame-level model
module tb_psum_accumulator;

    localparam int IN_W      = 3;
    localparam int ACC_W     = 4;
    localparam int CNT_W     = 8;
    localparam int MAX_BEATS = 4;
    localparam int ACC_MAX   = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst, clr, in_valid, in_last, in_ready;
    logic             out_ovf, out_err, out_valid, out_ready;
    logic [IN_W-1:0]  in_data;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_beats;

    int n_chk = 0;
    int n_fail = 0;

    // frame-level model: true (unclamped) running sum of the open frame, plus
    // the one result waiting at the output
    bit has_res, r_ovf, r_err;
    int r_data, r_beats, cur_sum, cur_cnt;

    always #5 clk = ~clk;

    psum_accumulator #(
        .IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_beats (out_beats),
        .out_ovf   (out_ovf),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        has_res = 0;
        cur_sum = 0;
        cur_cnt = 0;
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(has_res));
        if (has_res) begin
            check("out_data", 32'(out_data), r_data);
            check("out_beats", 32'(out_beats), r_beats);
            check("out_ovf", 32'(out_ovf), 32'(r_ovf));
            check("out_err", 32'(out_err), 32'(r_err));
        end
    endtask

    // one clock: drive, check readiness, advance model at the edge, check outputs
    task automatic step(input bit v, input int d, input bit l, input bit ordy, input bit c);
        bit rdy, beat, xfer;
        in_valid  = v;
        in_data   = IN_W'(d);
        in_last   = l;
        out_ready = ordy;
        clr       = c;
        #1;
        rdy = !c && (!has_res || ordy);
        check("in_ready", 32'(in_ready), 32'(rdy));
        beat = v && rdy;
        xfer = has_res && ordy;
        @(posedge clk);
        if (xfer) has_res = 0;
        if (c) begin
            cur_sum = 0;
            cur_cnt = 0;
        end
        if (beat) begin
            cur_sum += d;
            cur_cnt++;
            if (l || cur_cnt == MAX_BEATS) begin
                has_res = 1;
                r_data  = cur_sum > ACC_MAX ? ACC_MAX : cur_sum;
                r_beats = cur_cnt;
                r_ovf   = cur_sum > ACC_MAX;
                r_err   = !l;
                cur_sum = 0;
                cur_cnt = 0;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_outs", {out_data, out_beats, out_ovf, out_err}, 0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        clr      = 1'b0;
        model_reset();
        #1;
        check("post_rst_ready", 32'(in_ready), 1);
        check("post_rst_valid", 32'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // basic frame 2,4,3
        step(1, 2, 0, 1, 0);
        step(1, 4, 0, 1, 0);
        step(1, 3, 1, 1, 0);
        check("t2_data", 32'(out_data), 9);
        check("t2_beats", 32'(out_beats), 3);
        check("t2_flags", {out_ovf, out_err}, 0);
        step(0, 0, 0, 1, 0);

        // back-pressure, then same-cycle transfer + single-beat frame
        step(1, 5, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 6, 0, 0, 0);
        check("t3_held", 32'(out_data), 5);
        step(1, 7, 1, 1, 0);
        check("t3_nobubble", {out_valid, out_data}, {1'b1, 4'd7});
        step(0, 0, 0, 1, 0);

        // saturation
        step(1, 7, 0, 1, 0);
        step(1, 7, 0, 1, 0);
        step(1, 7, 1, 1, 0);
        check("t4_sat", {out_ovf, out_data}, {1'b1, 4'd15});
        step(0, 0, 0, 1, 0);

        // force-close at MAX_BEATS, 5th beat opens next frame
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        check("t5_force", {out_err, out_beats, out_data}, {1'b1, 8'd4, 4'd4});
        step(1, 1, 0, 1, 0);
        check("t5_next_open", 32'(out_valid), 0);
        step(1, 1, 1, 1, 0);
        check("t5_next_beats", 32'(out_beats), 2);
        step(0, 0, 0, 1, 0);

        // clr drops partial frame; clr in HOLD keeps result
        step(1, 3, 0, 1, 0);
        step(1, 3, 0, 1, 0);
        step(1, 3, 0, 1, 1);
        step(1, 1, 1, 0, 0);
        check("t6_data", {out_beats, out_data}, {8'd1, 4'd1});
        step(0, 0, 0, 0, 1);
        check("t6_hold_clr", {out_valid, out_data}, {1'b1, 4'd1});
        step(0, 0, 0, 1, 0);

        // reset mid-frame and mid-HOLD
        step(1, 2, 0, 1, 0);
        do_reset();
        step(1, 4, 1, 0, 0);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step($urandom_range(0, 9) < 7, int'($urandom_range(0, 7)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 29) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
